// File: rtl/swt16_lsu_pkg.sv
// rtl/swt16_lsu_pkg.sv - shared state, lane and access-size encodings for the load/store unit
package swt16_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_WRITE = 2'd2,
        RESP      = 2'd3
    } lsu_state_t;

    typedef enum logic {
        SIZE_WORD = 1'b0,
        SIZE_BYTE = 1'b1
    } lsu_size_t;

    localparam int LANE_LO    = 0;
    localparam int LANE_HI    = 1;
    localparam int BYTE_WIDTH = 8;

endpackage

// File: rtl/dmem_byte_lane.sv
// rtl/dmem_byte_lane.sv - byte extract with sign/zero extension and byte merge on a 16-bit word
module dmem_byte_lane
    import swt16_lsu_pkg::*;
(
    input  logic [2*BYTE_WIDTH-1:0] word,
    input  logic                    lane,
    input  logic                    sign_ext,
    input  logic [BYTE_WIDTH-1:0]   new_byte,
    output logic [2*BYTE_WIDTH-1:0] ext_word,
    output logic [2*BYTE_WIDTH-1:0] merged_word
);

    logic [BYTE_WIDTH-1:0] sel_byte;

    always_comb begin
        sel_byte    = (lane == 1'(LANE_LO)) ? word[BYTE_WIDTH-1:0] : word[2*BYTE_WIDTH-1:BYTE_WIDTH];
        ext_word    = {{BYTE_WIDTH{sign_ext & sel_byte[BYTE_WIDTH-1]}}, sel_byte};
        merged_word = word;
        if (lane == 1'(LANE_HI)) begin
            merged_word[2*BYTE_WIDTH-1:BYTE_WIDTH] = new_byte;
        end else begin
            merged_word[BYTE_WIDTH-1:0] = new_byte;
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit in front of a synchronous-read, word-wide data memory
module dmem_lsu
    import swt16_lsu_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_req_valid,
    output logic                  out_req_ready,
    input  logic                  in_req_write,
    input  logic                  in_req_byte,
    input  logic                  in_req_signed,
    input  logic [ADDR_WIDTH-1:0] in_req_addr,
    input  logic [WORD_WIDTH-1:0] in_req_wdata,
    output logic                  out_rsp_valid,
    output logic [WORD_WIDTH-1:0] out_rsp_rdata,
    output logic                  out_rsp_misaligned,
    output logic [ADDR_WIDTH-1:0] out_dmem_addr_rd,
    output logic [ADDR_WIDTH-1:0] out_dmem_addr_wr,
    output logic [WORD_WIDTH-1:0] out_dmem_word,
    output logic                  out_dmem_write_en,
    input  logic [WORD_WIDTH-1:0] in_dmem_word
);

    lsu_state_t            state, state_nx;
    lsu_size_t             req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [BYTE_WIDTH-1:0] req_byte_data;
    logic [WORD_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_misaligned_q;

    logic                  accept;
    logic                  in_misaligned;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] addr_rd;
    logic [ADDR_WIDTH-1:0] addr_wr;
    logic [WORD_WIDTH-1:0] wr_word;
    logic [WORD_WIDTH-1:0] ext_word;
    logic [WORD_WIDTH-1:0] merged_word;

    assign accept        = in_req_valid && (state == IDLE);
    assign in_misaligned = !in_req_byte && in_req_addr[0];

    dmem_byte_lane u_lane (
        .word        (in_dmem_word),
        .lane        (req_addr[0]),
        .sign_ext    (req_signed),
        .new_byte    (req_byte_data),
        .ext_word    (ext_word),
        .merged_word (merged_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_size      <= SIZE_WORD;
            req_signed    <= 1'b0;
            req_addr      <= '0;
            req_byte_data <= '0;
        end else if (accept) begin
            req_size      <= lsu_size_t'(in_req_byte);
            req_signed    <= in_req_signed;
            req_addr      <= in_req_addr;
            req_byte_data <= in_req_wdata[BYTE_WIDTH-1:0];
        end
    end

    // Stores and misaligned requests clear the result at accept; loads fill it in LOAD_WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_rdata_q      <= '0;
            rsp_misaligned_q <= 1'b0;
        end else if (accept) begin
            rsp_rdata_q      <= '0;
            rsp_misaligned_q <= in_misaligned;
        end else if (state == LOAD_WAIT) begin
            rsp_rdata_q      <= (req_size == SIZE_BYTE) ? ext_word : in_dmem_word;
            rsp_misaligned_q <= 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        write_en = 1'b0;
        addr_rd  = req_addr;
        addr_wr  = req_addr;
        wr_word  = merged_word;
        unique case (state)
            IDLE: begin
                addr_rd = in_req_addr;
                addr_wr = in_req_addr;
                wr_word = in_req_wdata;
                if (in_req_valid) begin
                    if (in_misaligned) begin
                        state_nx = RESP;
                    end else if (!in_req_write) begin
                        state_nx = LOAD_WAIT;
                    end else if (in_req_byte) begin
                        state_nx = RMW_WRITE;
                    end else begin
                        write_en = 1'b1;
                        state_nx = RESP;
                    end
                end
            end
            LOAD_WAIT: state_nx = RESP;
            RMW_WRITE: begin
                write_en = 1'b1;
                state_nx = RESP;
            end
            RESP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Memory-side outputs are forced low while reset is held so an aborted RMW never writes.
    assign out_dmem_write_en  = write_en && !reset;
    assign out_dmem_addr_rd   = reset ? '0 : addr_rd;
    assign out_dmem_addr_wr   = reset ? '0 : addr_wr;
    assign out_dmem_word      = reset ? '0 : wr_word;
    assign out_req_ready      = (state == IDLE) && !reset;
    assign out_rsp_valid      = (state == RESP);
    assign out_rsp_rdata      = rsp_rdata_q;
    assign out_rsp_misaligned = rsp_misaligned_q;

endmodule
